// File: rtl/axi3_mem_slave.sv
// axi3_mem_slave: AXI3 slave over a behavioural memory, one outstanding burst per direction.
// Define AXI_SLV_OOR_SLVERR_EN to answer SLVERR for word indices beyond MEM_WORDS instead of aliasing.
module axi3_mem_slave #(
  parameter int DATA_W    = 64,
  parameter int ID_W      = 9,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);
  localparam int BYTES = DATA_W / 8;
  localparam int BL = $clog2(BYTES);
  localparam int WL = $clog2(MEM_WORDS);
`ifdef AXI_SLV_OOR_SLVERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [3:0]        cnt;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              bad;
    logic              err;
  } cmd_t;
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  cmd_t wc_q, wc_d, rc_q, rc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic mem_we, r_load;
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step, mask;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~mask) | ((a + step) & mask) : a + step;
  endfunction
  // Commands that must not touch memory: oversize beats, reserved burst, illegal wrap length.
  function automatic logic bad_cmd(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    return int'(size) > BL || burst == 2'b11 || (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction
  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return OOR_EN && (|a[ADDR_W-1:BL+WL]);
  endfunction
  function automatic logic [WL-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[BL+WL-1:BL];
  endfunction
  always_comb begin
    w_state_d = w_state_q;
    wc_d = wc_q;
    mem_we = 1'b0;
    awready = w_state_q == W_IDLE;
    wready = w_state_q == W_DATA;
    bvalid = w_state_q == W_RESP;
    bid = wc_q.id;
    bresp = bvalid && wc_q.err ? 2'b10 : 2'b00;
    if (awvalid && awready) begin
      wc_d = '{id: awid, addr: awaddr, len: awlen, cnt: 4'd0, size: awsize, burst: awburst,
               bad: bad_cmd(awlen, awsize, awburst), err: bad_cmd(awlen, awsize, awburst)};
      w_state_d = W_DATA;
    end
    if (wvalid && wready) begin
      mem_we = !wc_q.bad && !oor(wc_q.addr);
      wc_d.err = wc_q.err || oor(wc_q.addr) || wid != wc_q.id || wlast != (wc_q.cnt == wc_q.len);
      wc_d.addr = next_addr(wc_q.addr, wc_q.len, wc_q.size, wc_q.burst);
      wc_d.cnt = wc_q.cnt + 4'd1;
      w_state_d = wc_q.cnt == wc_q.len ? W_RESP : W_DATA;
    end
    if (bvalid && bready) w_state_d = W_IDLE;
  end
  // rdata only reloads on a fetch, so a stalled beat never sees later writes.
  always_comb begin
    r_state_d = r_state_q;
    rc_d = rc_q;
    r_load = 1'b0;
    arready = r_state_q == R_IDLE;
    rvalid = r_state_q == R_DATA;
    rid = rc_q.id;
    rresp = rc_q.err ? 2'b10 : 2'b00;
    rlast = rvalid && rc_q.cnt == rc_q.len;
    if (arvalid && arready) begin
      rc_d = '{id: arid, addr: araddr, len: arlen, cnt: 4'd0, size: arsize, burst: arburst,
               bad: bad_cmd(arlen, arsize, arburst), err: bad_cmd(arlen, arsize, arburst) || oor(araddr)};
      r_state_d = R_DATA;
      r_load = 1'b1;
    end else if (rvalid && rready) begin
      rc_d.addr = next_addr(rc_q.addr, rc_q.len, rc_q.size, rc_q.burst);
      rc_d.cnt = rc_q.cnt + 4'd1;
      rc_d.err = rc_q.err || oor(rc_d.addr);
      r_state_d = rlast ? R_IDLE : R_DATA;
      r_load = !rlast;
    end
    rdata_d = !r_load ? rdata_q : (rc_d.bad || oor(rc_d.addr)) ? '0 : mem[widx(rc_d.addr)];
    rdata = rdata_q;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wc_q <= '0;
      rc_q <= '0;
      rdata_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wc_q <= wc_d;
      rc_q <= rc_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge aclk) begin
    if (mem_we && !areset)
      for (int i = 0; i < BYTES; i++)
        if (wstrb[i]) mem[widx(wc_q.addr)][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule
